// File: rtl/layer_sequencer_if.sv
// Bus bundle between the layer sequencer and its surroundings: upstream
// activation stream, neuron broadcast/result lines, downstream result stream
// and run control/status.
interface layer_sequencer_if #(
    parameter int numNeuron = 30,
    parameter int dataWidth = 16
);
    logic                           start;
    logic [dataWidth-1:0]           in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic [dataWidth-1:0]           neuron_in;
    logic                           neuron_in_valid;
    logic [numNeuron*dataWidth-1:0] neuron_out;
    logic [numNeuron-1:0]           neuron_outvalid;
    logic [dataWidth-1:0]           out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic                           out_last;
    logic                           busy;
    logic                           done;
    logic                           err;

    // Sequencer side
    modport master (
        input  start, in_data, in_valid, neuron_out, neuron_outvalid, out_ready,
        output in_ready, neuron_in, neuron_in_valid, out_data, out_valid,
               out_last, busy, done, err
    );

    // System / environment side
    modport slave (
        output start, in_data, in_valid, neuron_out, neuron_outvalid, out_ready,
        input  in_ready, neuron_in, neuron_in_valid, out_data, out_valid,
               out_last, busy, done, err
    );
endinterface

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: streams numInput activations to all
// neurons, collects every neuron's result (with a watchdog on the wait), then
// streams the results downstream in neuron-index order.
module layer_sequencer #(
    parameter int numInput      = 784,
    parameter int numNeuron     = 30,
    parameter int dataWidth     = 16,
    parameter int timeoutCycles = 64
) (
    input logic               clk,
    input logic               rst,
    layer_sequencer_if.master bus
);

    localparam int IN_CNT_W  = $clog2(numInput + 1);
    localparam int OUT_IDX_W = (numNeuron > 1) ? $clog2(numNeuron) : 1;
    localparam int WAIT_W    = $clog2(timeoutCycles + 1);

    localparam logic [IN_CNT_W-1:0]  IN_LAST   = IN_CNT_W'(numInput - 1);
    localparam logic [OUT_IDX_W-1:0] OUT_LAST  = OUT_IDX_W'(numNeuron - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(timeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, SEND} state_t;

    state_t                 state_q, state_d;
    logic [IN_CNT_W-1:0]    in_cnt_q, in_cnt_d;
    logic [OUT_IDX_W-1:0]   out_idx_q, out_idx_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [numNeuron-1:0]   mask_q, mask_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   clear_run;

    logic [dataWidth-1:0]   nin_q;
    logic                   nin_vld_q;
    logic [dataWidth-1:0]   res_q [numNeuron];

    logic                   accept;

    assign accept = bus.in_valid && (state_q == STREAM);

    // Next-state, counter and flag updates for the layer run
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        out_idx_d  = out_idx_q;
        wait_cnt_d = wait_cnt_q;
        mask_d     = mask_q;
        err_d      = err_q;
        done_d     = 1'b0;
        clear_run  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = STREAM;
                    in_cnt_d   = '0;
                    out_idx_d  = '0;
                    wait_cnt_d = '0;
                    mask_d     = '0;
                    err_d      = 1'b0;
                    clear_run  = 1'b1;
                end
            end
            STREAM: begin
                if (accept) begin
                    in_cnt_d = in_cnt_q + IN_CNT_W'(1);
                    if (in_cnt_q == IN_LAST) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Captures landing this cycle count toward completion.
                mask_d     = mask_q | bus.neuron_outvalid;
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (&mask_d) begin
                    state_d = SEND;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (out_idx_q == OUT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        out_idx_d = out_idx_q + OUT_IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            in_cnt_q   <= '0;
            out_idx_q  <= '0;
            wait_cnt_q <= '0;
            mask_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_idx_q  <= out_idx_d;
            wait_cnt_q <= wait_cnt_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // Registered broadcast of each accepted activation to the neurons
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nin_q     <= '0;
            nin_vld_q <= 1'b0;
        end else begin
            nin_vld_q <= accept;
            if (accept) begin
                nin_q <= bus.in_data;
            end
        end
    end

    // Result capture; cleared at run start so uncaptured neurons read as 0
    always_ff @(posedge clk) begin
        for (int k = 0; k < numNeuron; k++) begin
            if (clear_run) begin
                res_q[k] <= '0;
            end else if ((state_q == WAIT) && bus.neuron_outvalid[k]) begin
                res_q[k] <= bus.neuron_out[k*dataWidth +: dataWidth];
            end
        end
    end

    // out_data is gated by SEND so it reads 0 whenever out_valid is low,
    // which keeps the result array itself free of reset.
    assign bus.in_ready        = (state_q == STREAM);
    assign bus.neuron_in       = nin_q;
    assign bus.neuron_in_valid = nin_vld_q;
    assign bus.out_valid       = (state_q == SEND);
    assign bus.out_data        = (state_q == SEND) ? res_q[out_idx_q] : '0;
    assign bus.out_last        = (state_q == SEND) && (out_idx_q == OUT_LAST);
    assign bus.busy            = (state_q != IDLE);
    assign bus.done            = done_q;
    assign bus.err             = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: table of hand-computed layer runs, randomized
// runs scored by a reference model, and a mid-run reset sequence.
module tb_layer_sequencer;
    localparam int NI = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int T  = 8;
    localparam int W  = NN * DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    layer_sequencer_if #(.numNeuron(NN), .dataWidth(DW)) bus ();

    layer_sequencer #(
        .numInput(NI), .numNeuron(NN), .dataWidth(DW), .timeoutCycles(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [NI-1:0][DW-1:0] ins;
        logic [NN-1:0][7:0]    dly;   // 0 = neuron never answers
        logic [NN-1:0][DW-1:0] res;
        logic [NN-1:0][DW-1:0] expo;
        logic                  experr;
        logic [1:0]            gap;   // 0 continuous, 1 toggling, 2 random
        logic [1:0]            rdy;   // 0 always, 1 random, 2 stall beat 1
        logic                  sis;   // pulse start during SEND
    } vec_t;

    vec_t tbl [8];
    int   nv = 0;

    logic [DW-1:0] c_ins [NI];
    int            c_dly [NN];
    logic [DW-1:0] c_res [NN];
    logic [DW-1:0] c_exp [NN];
    bit            c_err;
    int            c_gap, c_rdy, c_wend;
    bit            c_sis;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic add_vec(input logic [DW-1:0] i0, i1, i2, i3,
                           input int d0, d1, d2,
                           input logic [DW-1:0] r0, r1, r2, e0, e1, e2,
                           input bit er, input int g, input int rd, input bit s);
        tbl[nv].ins[0] = i0; tbl[nv].ins[1] = i1; tbl[nv].ins[2] = i2; tbl[nv].ins[3] = i3;
        tbl[nv].dly[0] = 8'(d0); tbl[nv].dly[1] = 8'(d1); tbl[nv].dly[2] = 8'(d2);
        tbl[nv].res[0] = r0; tbl[nv].res[1] = r1; tbl[nv].res[2] = r2;
        tbl[nv].expo[0] = e0; tbl[nv].expo[1] = e1; tbl[nv].expo[2] = e2;
        tbl[nv].experr = er;
        tbl[nv].gap = 2'(g);
        tbl[nv].rdy = 2'(rd);
        tbl[nv].sis = s;
        nv++;
    endtask

    // Wait phase lasts until the slowest answer if all answer in time,
    // otherwise exactly T cycles.
    function automatic bit all_in_time();
        bit ok = 1'b1;
        for (int k = 0; k < NN; k++)
            if (c_dly[k] < 1 || c_dly[k] > T) ok = 1'b0;
        return ok;
    endfunction

    function automatic int wait_len();
        int mx = 0;
        if (!all_in_time()) return T;
        for (int k = 0; k < NN; k++)
            if (c_dly[k] > mx) mx = c_dly[k];
        return mx;
    endfunction

    function automatic void model_outputs();
        c_wend = wait_len();
        c_err  = !all_in_time();
        for (int k = 0; k < NN; k++)
            c_exp[k] = (c_dly[k] >= 1 && c_dly[k] <= c_wend) ? c_res[k] : '0;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready), 0);
        chk({tag, "_nin"},       32'(bus.neuron_in), 0);
        chk({tag, "_nin_vld"},   32'(bus.neuron_in_valid), 0);
        chk({tag, "_out_data"},  32'(bus.out_data), 0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_out_last"},  32'(bus.out_last), 0);
        chk({tag, "_busy"},      32'(bus.busy), 0);
        chk({tag, "_done"},      32'(bus.done), 0);
        chk({tag, "_err"},       32'(bus.err), 0);
    endtask

    // One full layer run. Cycle index cyc counts falling edges after the
    // cycle where start was seen; neuron k answers d cycles into WAIT.
    task automatic run_layer(input string tag);
        int sent = 0, t_last = -1, idx = 0, cyc = 0, hold = 0;
        bit fin = 1'b0;
        bit v, r;
        logic [DW-1:0] got [$];
        logic [W-1:0] packed_res;
        logic [NN-1:0] ov;
        for (int k = 0; k < NN; k++) packed_res[k*DW +: DW] = c_res[k];
        @(negedge clk);
        bus.start = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.neuron_outvalid = '0;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy_on"}, 32'(bus.busy), 1);
        chk({tag, "_err_clr"}, 32'(bus.err), 0);
        while (!fin && cyc < 200) begin
            if (bus.neuron_in_valid) begin
                got.push_back(bus.neuron_in);
                if (got.size() == NI) t_last = cyc;
            end
            chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(sent < NI));
            if (sent < NI) begin
                case (c_gap)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 0);
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                bus.in_valid = v;
                bus.in_data  = v ? c_ins[sent] : DW'($urandom);
                if (v && bus.in_ready) sent++;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = 16'hdead;
            end
            if (t_last < 0) begin
                bus.neuron_outvalid = NN'($urandom);
                bus.neuron_out      = W'({$urandom, $urandom});
            end else begin
                bus.neuron_out = packed_res;
                for (int k = 0; k < NN; k++)
                    ov[k] = (c_dly[k] > 0) && (cyc == t_last + c_dly[k] - 1);
                bus.neuron_outvalid = ov;
            end
            if (t_last >= 0 && cyc >= t_last + c_wend) begin
                if (idx < NN) begin
                    chk({tag, "_out_valid"}, 32'(bus.out_valid), 1);
                    chk({tag, "_out_data"},  32'(bus.out_data), 32'(c_exp[idx]));
                    chk({tag, "_out_last"},  32'(bus.out_last), 32'(idx == NN - 1));
                    chk({tag, "_busy_send"}, 32'(bus.busy), 1);
                    if (cyc == t_last + c_wend) chk({tag, "_err"}, 32'(bus.err), 32'(c_err));
                    case (c_rdy)
                        0:       r = 1'b1;
                        1:       r = 1'($urandom_range(0, 1));
                        default: begin
                            if (idx == 1 && hold < 3) begin r = 1'b0; hold++; end
                            else r = 1'b1;
                        end
                    endcase
                    bus.out_ready = r;
                    bus.start     = c_sis && (idx == 1);
                    if (r) idx++;
                end else begin
                    chk({tag, "_done"},      32'(bus.done), 1);
                    chk({tag, "_busy_off"},  32'(bus.busy), 0);
                    chk({tag, "_ov_off"},    32'(bus.out_valid), 0);
                    chk({tag, "_err_hold"},  32'(bus.err), 32'(c_err));
                    bus.out_ready = 1'b0;
                    bus.start     = 1'b0;
                    fin = 1'b1;
                end
            end else begin
                chk({tag, "_ov_early"},   32'(bus.out_valid), 0);
                chk({tag, "_done_early"}, 32'(bus.done), 0);
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_completed"}, 32'(fin), 1);
        chk({tag, "_nin_count"}, 32'(got.size()), NI);
        for (int i = 0; i < NI; i++)
            if (i < got.size()) chk({tag, "_nin_val"}, 32'(got[i]), 32'(c_ins[i]));
        chk({tag, "_done_pulse"}, 32'(bus.done), 0);
        chk({tag, "_idle"},       32'(bus.busy), 0);
        bus.in_valid = 1'b0;
        bus.neuron_outvalid = '0;
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < NI; i++) c_ins[i] = tbl[v].ins[i];
        for (int k = 0; k < NN; k++) begin
            c_dly[k] = int'(tbl[v].dly[k]);
            c_res[k] = tbl[v].res[k];
            c_exp[k] = tbl[v].expo[k];
        end
        c_err  = tbl[v].experr;
        c_gap  = int'(tbl[v].gap);
        c_rdy  = int'(tbl[v].rdy);
        c_sis  = tbl[v].sis;
        c_wend = wait_len();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.neuron_out = '0; bus.neuron_outvalid = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst_init");
        rst = 1'b1;

        //       inputs                          delays    results                    expected                   err gap rdy sis
        add_vec(16'd1, 16'd2, 16'd3, 16'd4,       6, 6, 6, 16'd10, 16'd20, 16'd30,    16'd10, 16'd20, 16'd30,    0, 0, 0, 0);
        add_vec(16'd1, 16'd2, 16'd3, 16'd4,       6, 6, 6, 16'd10, 16'd20, 16'd30,    16'd10, 16'd20, 16'd30,    0, 1, 0, 0);
        add_vec(16'd5, 16'd6, 16'd7, 16'd8,       3, 5, 1, 16'h111, 16'h222, 16'h333, 16'h111, 16'h222, 16'h333, 0, 0, 0, 0);
        add_vec(16'd9, 16'd10, 16'd11, 16'd12,    6, 0, 6, 16'd7, 16'd8, 16'd9,       16'd7, 16'd0, 16'd9,       1, 0, 0, 0);
        add_vec(16'hffff, 16'h8000, 16'h7fff, 16'h1, 8, 8, 8, 16'd1, 16'd2, 16'd3,    16'd1, 16'd2, 16'd3,       0, 2, 0, 0);
        add_vec(16'd2, 16'd4, 16'd6, 16'd8,       4, 2, 6, 16'haaaa, 16'hbbbb, 16'hcccc, 16'haaaa, 16'hbbbb, 16'hcccc, 0, 0, 2, 1);
        add_vec(16'd3, 16'd3, 16'd3, 16'd3,       9, 2, 3, 16'h1234, 16'h5678, 16'h9abc, 16'h0, 16'h5678, 16'h9abc, 1, 0, 0, 0);

        for (int v = 0; v < nv; v++) begin
            load_vec(v);
            run_layer($sformatf("vec%0d", v));
        end

        for (int n = 0; n < 12; n++) begin
            int sel;
            for (int i = 0; i < NI; i++) c_ins[i] = DW'($urandom);
            for (int k = 0; k < NN; k++) begin
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      c_dly[k] = 0;
                else if (sel == 9) c_dly[k] = T + int'($urandom_range(1, 3));
                else               c_dly[k] = int'($urandom_range(1, T));
                c_res[k] = DW'($urandom);
            end
            c_gap = 2;
            c_rdy = 1;
            c_sis = 1'($urandom_range(0, 1));
            model_outputs();
            run_layer($sformatf("rand%0d", n));
        end

        @(negedge clk);
        bus.start = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0011;
        @(negedge clk);
        bus.in_data = 16'h0022;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("midrst_pre_busy", 32'(bus.busy), 1);
        chk("midrst_pre_nin",  32'(bus.neuron_in), 32'h22);
        #2 rst = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        load_vec(0);
        run_layer("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
